// File: rtl/ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_ctrl
// Description : Instruction fetch sequencer. Issues imem reads from the PC,
//               buffers returned words in a prefetch FIFO and presents
//               {pc, instr} to decode. Optional IFETCH_STATS_EN adds
//               fetch/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0]        stat_fetched,
  output logic [31:0]        stat_flushed
`endif
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam int c_OCC_W = c_CNT_W + 1;

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_inflight_pc;
  logic                r_inflight;
  logic [ADDR_W-1:0]   r_fifo_pc    [DEPTH];
  logic [INSTR_W-1:0]  r_fifo_instr [DEPTH];
  logic [c_PTR_W-1:0]  r_head;
  logic [c_PTR_W-1:0]  r_tail;
  logic [c_CNT_W-1:0]  r_count;

  logic                w_pop;
  logic                w_push;
  logic                w_issue;
  logic [c_OCC_W-1:0]  w_occupancy;
  logic                w_unused;

  function automatic logic [c_PTR_W-1:0] f_next_ptr(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
  endfunction

  // Low address bits of redirect targets are discarded on purpose.
  assign w_unused = ^redirect_pc[1:0];

  assign out_valid = reset & (r_count != '0);
  assign out_pc    = out_valid ? r_fifo_pc[r_head]    : '0;
  assign out_instr = out_valid ? r_fifo_instr[r_head] : '0;

  assign w_pop  = out_valid & out_ready;
  assign w_push = r_inflight & ~redirect;

  // Slots already claimed after this cycle's pop; the inflight word needs one.
  assign w_occupancy = {1'b0, r_count}
                     + {{c_CNT_W{1'b0}}, r_inflight}
                     - {{c_CNT_W{1'b0}}, w_pop};

  assign w_issue = reset & ~redirect & (r_state == S_RUN)
                 & (w_occupancy < c_OCC_W'(DEPTH));

  assign imem_en   = w_issue;
  assign imem_addr = r_pc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_RUN;
      r_pc          <= {RESET_PC[ADDR_W-1:2], 2'b00};
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
    end else begin
      case (r_state)
        S_RUN:   if (halt)  r_state <= S_HALT;
        S_HALT:  if (!halt) r_state <= S_RUN;
        default: r_state <= S_RUN;
      endcase

      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
      end

      if (redirect) begin
        r_pc    <= {redirect_pc[ADDR_W-1:2], 2'b00};
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_issue) begin
          r_pc <= r_pc + ADDR_W'(4);
        end
        if (w_push) begin
          r_tail <= f_next_ptr(r_tail);
        end
        if (w_pop) begin
          r_head <= f_next_ptr(r_head);
        end
        r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
      end
    end
  end

  // Entry storage needs no reset; out_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_tail]    <= r_inflight_pc;
      r_fifo_instr[r_tail] <= imem_data;
    end
  end

`ifdef IFETCH_STATS_EN
  logic [31:0] r_stat_fetched;
  logic [31:0] r_stat_flushed;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stat_fetched <= '0;
      r_stat_flushed <= '0;
    end else if (redirect) begin
      r_stat_flushed <= r_stat_flushed + 32'(r_count) + 32'(r_inflight);
    end else if (w_pop) begin
      r_stat_fetched <= r_stat_fetched + 32'd1;
    end
  end

  assign stat_fetched = r_stat_fetched;
  assign stat_flushed = r_stat_flushed;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_ctrl
// Description : Directed plus random bench for ifetch_ctrl against a
//               queue-based fetch model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_ctrl;

  localparam int          ADDR_W   = 32;
  localparam int          INSTR_W  = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic               clk = 1'b0;
  logic               reset;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_en;
  logic [INSTR_W-1:0] imem_data;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               halt;
  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  out_pc;
  logic [INSTR_W-1:0] out_instr;
`ifdef IFETCH_STATS_EN
  logic [31:0]        stat_fetched;
  logic [31:0]        stat_flushed;
`endif

  always #5 clk = ~clk;

  ifetch_ctrl #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_en     (imem_en),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr)
`ifdef IFETCH_STATS_EN
    ,
    .stat_fetched(stat_fetched),
    .stat_flushed(stat_flushed)
`endif
  );

  // imem word i holds value i; non-issue cycles return junk.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a >> 2;
  endfunction

  always @(posedge clk) imem_data <= imem_en ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_inflight_pc;
  bit          m_inflight;
  bit          m_halted;
  logic [31:0] m_fetched;
  logic [31:0] m_flushed;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc          = RESET_PC & ~32'h3;
    m_inflight    = 1'b0;
    m_inflight_pc = '0;
    m_halted      = 1'b0;
    m_fetched     = '0;
    m_flushed     = '0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input bit rst_n, input bit rd, input logic [31:0] rpc,
                      input bit hl, input bit rdy);
    bit     e_valid, e_pop, e_en;
    int     occ;
    entry_t head;
    @(negedge clk);
    reset       = rst_n;
    redirect    = rd;
    redirect_pc = rpc;
    halt        = hl;
    out_ready   = rdy;
    #1;
    e_valid = rst_n && (m_q.size() != 0);
    head    = e_valid ? m_q[0] : '0;
    e_pop   = e_valid && rdy;
    occ     = m_q.size() + int'(m_inflight) - int'(e_pop);
    e_en    = rst_n && !rd && !m_halted && (occ < DEPTH);

    check("out_valid", 64'(out_valid), 64'(e_valid));
    check("out_pc",    64'(out_pc),    64'(head.pc));
    check("out_instr", 64'(out_instr), 64'(head.instr));
    check("imem_en",   64'(imem_en),   64'(e_en));
    if (e_en) check("imem_addr", 64'(imem_addr), 64'(m_pc));
`ifdef IFETCH_STATS_EN
    if (rst_n) begin
      check("stat_fetched", 64'(stat_fetched), 64'(m_fetched));
      check("stat_flushed", 64'(stat_flushed), 64'(m_flushed));
    end
`endif

    if (!rst_n) begin
      model_reset();
    end else if (rd) begin
      m_flushed  = m_flushed + m_q.size() + int'(m_inflight);
      m_q.delete();
      m_inflight = 1'b0;
      m_pc       = rpc & ~32'h3;
      m_halted   = hl;
    end else begin
      if (e_pop) begin
        void'(m_q.pop_front());
        m_fetched = m_fetched + 1;
      end
      if (m_inflight) m_q.push_back('{pc: m_inflight_pc, instr: mem_word(m_inflight_pc)});
      m_inflight = e_en;
      if (e_en) begin
        m_inflight_pc = m_pc;
        m_pc          = m_pc + 32'd4;
      end
      m_halted = hl;
    end
    @(posedge clk);
  endtask

  initial begin
    bit          hl_r;
    logic [31:0] rpc;
    reset       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    halt        = 1'b0;
    out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // held in reset
    repeat (2) step(0, 0, 0, 0, 1);
    // streaming from RESET_PC
    repeat (8) step(1, 0, 0, 0, 1);
    // backpressure fills the FIFO, then drain
    repeat (6) step(1, 0, 0, 0, 0);
    repeat (6) step(1, 0, 0, 0, 1);
    // redirect with a full FIFO, unaligned target
    repeat (2) step(1, 0, 0, 0, 0);
    step(1, 1, 32'h43, 0, 1);
    repeat (4) step(1, 0, 0, 0, 1);
    // halt window
    repeat (4) step(1, 0, 0, 1, 1);
    repeat (6) step(1, 0, 0, 0, 1);
    // reset mid-stream
    step(0, 0, 0, 0, 1);
    repeat (14) step(1, 0, 0, 0, 1);
    // back-to-back redirects, last wins
    step(1, 1, 32'h100, 0, 1);
    step(1, 1, 32'h200, 0, 1);
    repeat (4) step(1, 0, 0, 0, 1);
    // redirect while halted, then resume across the address wrap
    repeat (2) step(1, 0, 0, 1, 0);
    step(1, 1, 32'hFFFF_FFF7, 1, 1);
    step(1, 0, 0, 1, 1);
    repeat (8) step(1, 0, 0, 0, 1);

    hl_r = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0) hl_r = ~hl_r;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                        : 32'($urandom);
      step($urandom_range(0, 99) != 0, $urandom_range(0, 19) == 0, rpc, hl_r,
           $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
